stdp_pair_scheduler: RTL and testbench

Sequencer for the coupled two-neuron STDP experiment. One shared Izhikevich step unit advances both neurons once per `apply`: neuron 1 (presynaptic, driven by external current), then neuron 2 (postsynaptic, driven by the synaptic weight). The block then updates decaying spike traces and applies pair-based STDP to the single synaptic weight. It sits between the top-level testbench/host and the neuron datapath and owns all timestep ordering and weight state.

---
 rtl/stdp_pair_scheduler.sv | 179 +++++++++++++++++
 tb/tb_stdp_pair_scheduler.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/stdp_pair_scheduler.sv
// Timestep sequencer for a coupled pre/post neuron pair: drives a shared step unit for
// both neurons, then updates decaying spike traces and the pair-based STDP weight.
module stdp_pair_scheduler #(
    parameter int N = 32,
    parameter int Q = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         apply,
    input  logic         init,
    input  logic [N-1:0] i_ext,
    input  logic [N-1:0] weight_init,
    input  logic [N-1:0] weight_min,
    input  logic [N-1:0] weight_max,
    input  logic [N-1:0] a_plus,
    input  logic [N-1:0] a_minus,
    input  logic [N-1:0] decay,
    output logic         step_req,
    output logic         step_sel,
    output logic [N-1:0] step_current,
    input  logic         step_ack,
    input  logic         step_spike,
    output logic         busy,
    output logic         done,
    output logic         is_spiking1,
    output logic         is_spiking2,
    output logic [N-1:0] weight,
    output logic [N-1:0] trace1,
    output logic [N-1:0] trace2
);

    typedef enum logic [2:0] {IDLE, STEP1, STEP2, TRACE, UPDATE, DONE} state_t;

    localparam logic signed [N:0] ONE_W = {{(N-Q){1'b0}}, 1'b1, {Q{1'b0}}};
    localparam logic signed [N:0] MAX_W = {2'b00, {(N-1){1'b1}}};

    // Full-width signed product, floor-shifted by Q, low N bits kept.
    function automatic logic signed [N-1:0] mul_q(input logic signed [N-1:0] x,
                                                  input logic signed [N-1:0] y);
        logic signed [2*N-1:0] xe, ye;
        xe = (2*N)'(x);
        ye = (2*N)'(y);
        return N'((xe * ye) >>> Q);
    endfunction

    function automatic logic signed [N-1:0] trace_sat(input logic signed [N-1:0] base,
                                                      input logic inc);
        logic signed [N:0] s;
        s = (N+1)'(base) + (inc ? ONE_W : '0);
        return (s > MAX_W) ? MAX_W[N-1:0] : s[N-1:0];
    endfunction

    function automatic logic signed [N-1:0] weight_clamp(input logic signed [N+1:0] sum,
                                                         input logic signed [N-1:0] lo,
                                                         input logic signed [N-1:0] hi);
        if (sum < (N+2)'(lo)) return lo;
        if (sum > (N+2)'(hi)) return hi;
        return sum[N-1:0];
    endfunction

    state_t                state_q, state_d;
    logic                  step_req_q, step_req_d;
    logic                  step_sel_q, step_sel_d;
    logic signed [N-1:0]   step_current_q, step_current_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  spike1_q, spike1_d;
    logic                  spike2_q, spike2_d;
    logic signed [N-1:0]   weight_q, weight_d;
    logic signed [N-1:0]   trace1_q, trace1_d;
    logic signed [N-1:0]   trace2_q, trace2_d;
    logic signed [N+1:0]   w_sum;
    logic signed [N-1:0]   ltp, ltd;

    // LTP/LTD terms read the traces already refreshed in TRACE.
    assign ltp   = spike2_q ? mul_q($signed(a_plus), trace1_q) : '0;
    assign ltd   = spike1_q ? mul_q($signed(a_minus), trace2_q) : '0;
    assign w_sum = (N+2)'(weight_q) + (N+2)'(ltp) - (N+2)'(ltd);

    always_comb begin
        state_d        = state_q;
        step_req_d     = step_req_q;
        step_sel_d     = step_sel_q;
        step_current_d = step_current_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        spike1_d       = spike1_q;
        spike2_d       = spike2_q;
        weight_d       = weight_q;
        trace1_d       = trace1_q;
        trace2_d       = trace2_q;
        case (state_q)
            IDLE: begin
                if (init) begin
                    weight_d = $signed(weight_init);
                    trace1_d = '0;
                    trace2_d = '0;
                    spike1_d = 1'b0;
                    spike2_d = 1'b0;
                end else if (apply) begin
                    state_d        = STEP1;
                    busy_d         = 1'b1;
                    step_req_d     = 1'b1;
                    step_sel_d     = 1'b0;
                    step_current_d = $signed(i_ext);
                end
            end
            STEP1: begin
                if (step_ack) begin
                    spike1_d       = step_spike;
                    state_d        = STEP2;
                    step_sel_d     = 1'b1;
                    step_current_d = step_spike ? weight_q : '0;
                end
            end
            STEP2: begin
                if (step_ack) begin
                    spike2_d   = step_spike;
                    state_d    = TRACE;
                    step_req_d = 1'b0;
                end
            end
            TRACE: begin
                trace1_d = trace_sat(mul_q(trace1_q, $signed(decay)), spike1_q);
                trace2_d = trace_sat(mul_q(trace2_q, $signed(decay)), spike2_q);
                state_d  = UPDATE;
            end
            UPDATE: begin
                weight_d = weight_clamp(w_sum, $signed(weight_min), $signed(weight_max));
                done_d   = 1'b1;
                state_d  = DONE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            step_req_q     <= 1'b0;
            step_sel_q     <= 1'b0;
            step_current_q <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            spike1_q       <= 1'b0;
            spike2_q       <= 1'b0;
            weight_q       <= '0;
            trace1_q       <= '0;
            trace2_q       <= '0;
        end else begin
            state_q        <= state_d;
            step_req_q     <= step_req_d;
            step_sel_q     <= step_sel_d;
            step_current_q <= step_current_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            spike1_q       <= spike1_d;
            spike2_q       <= spike2_d;
            weight_q       <= weight_d;
            trace1_q       <= trace1_d;
            trace2_q       <= trace2_d;
        end
    end

    assign step_req     = step_req_q;
    assign step_sel     = step_sel_q;
    assign step_current = step_current_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign is_spiking1  = spike1_q;
    assign is_spiking2  = spike2_q;
    assign weight       = weight_q;
    assign trace1       = trace1_q;
    assign trace2       = trace2_q;

endmodule

// File: tb/tb_stdp_pair_scheduler.sv
// Directed and randomized timesteps for stdp_pair_scheduler against a behavioural STDP model.
module tb_stdp_pair_scheduler;

    logic        clk = 1'b0;
    logic        reset, apply, init, step_ack, step_spike;
    logic [31:0] i_ext, weight_init, weight_min, weight_max, a_plus, a_minus, decay;
    logic        step_req, step_sel, busy, done, is_spiking1, is_spiking2;
    logic [31:0] step_current, weight, trace1, trace2;

    int total = 0;
    int bad   = 0;

    // Reference state of the experiment, kept as plain integers.
    longint m_w, m_t1, m_t2, m_min, m_max, m_ap, m_am, m_dec;
    bit     m_s1, m_s2;

    stdp_pair_scheduler #(.N(32), .Q(16)) dut (
        .clk(clk), .reset(reset), .apply(apply), .init(init), .i_ext(i_ext),
        .weight_init(weight_init), .weight_min(weight_min), .weight_max(weight_max),
        .a_plus(a_plus), .a_minus(a_minus), .decay(decay),
        .step_req(step_req), .step_sel(step_sel), .step_current(step_current),
        .step_ack(step_ack), .step_spike(step_spike), .busy(busy), .done(done),
        .is_spiking1(is_spiking1), .is_spiking2(is_spiking2),
        .weight(weight), .trace1(trace1), .trace2(trace2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic longint fx_mul(input longint a, input longint b);
        return (a * b) >>> 16;
    endfunction

    task automatic check_state(input string tag);
        check({tag, "_w"}, weight, 32'(m_w));
        check({tag, "_t1"}, trace1, 32'(m_t1));
        check({tag, "_t2"}, trace2, 32'(m_t2));
        check({tag, "_s1"}, {31'd0, is_spiking1}, {31'd0, m_s1});
        check({tag, "_s2"}, {31'd0, is_spiking2}, {31'd0, m_s2});
    endtask

    task automatic do_init(input longint w0, input longint mn, input longint mx,
                           input longint ap, input longint am, input longint dc);
        weight_init = 32'(w0); weight_min = 32'(mn); weight_max = 32'(mx);
        a_plus = 32'(ap); a_minus = 32'(am); decay = 32'(dc);
        m_w = w0; m_min = mn; m_max = mx; m_ap = ap; m_am = am; m_dec = dc;
        m_t1 = 0; m_t2 = 0; m_s1 = 0; m_s2 = 0;
        init = 1'b1;
        tick();
        init = 1'b0;
        check_state("init");
        check("init_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic run_step(input bit s1, input bit s2, input int dly, input bit poke);
        longint      cur2, sum;
        logic [31:0] cur1;
        int          n, w;
        cur2 = s1 ? m_w : 0;
        cur1 = $urandom;
        i_ext = cur1;
        apply = 1'b1;
        tick();
        apply = 1'b0;
        n = 0;
        check("busy_start", {31'd0, busy}, 32'd1);
        for (int ph = 0; ph < 2; ph++) begin
            w = 0;
            while (step_req !== 1'b1 && w < 20) begin tick(); n++; w++; end
            check("req_seen", {31'd0, step_req}, 32'd1);
            check("sel", {31'd0, step_sel}, 32'(ph));
            check("cur", step_current, (ph == 1) ? 32'(cur2) : cur1);
            for (int d = 0; d < dly; d++) begin
                apply = poke;
                tick(); n++;
                apply = 1'b0;
                check("req_hold", {31'd0, step_req}, 32'd1);
                check("sel_hold", {31'd0, step_sel}, 32'(ph));
                check("cur_hold", step_current, (ph == 1) ? 32'(cur2) : cur1);
            end
            step_ack = 1'b1;
            step_spike = (ph == 1) ? s2 : s1;
            tick(); n++;
            step_ack = 1'b0;
            step_spike = 1'b0;
        end
        w = 0;
        while (done !== 1'b1 && w < 20) begin tick(); n++; w++; end
        check("done_seen", {31'd0, done}, 32'd1);
        // Cycle numbering starts at 1 for the cycle following the apply edge.
        check("done_cycle", 32'(n + 1), 32'(5 + 2 * dly));
        m_s1 = s1; m_s2 = s2;
        m_t1 = fx_mul(m_t1, m_dec) + (s1 ? 65536 : 0);
        m_t2 = fx_mul(m_t2, m_dec) + (s2 ? 65536 : 0);
        if (m_t1 > 64'h7FFFFFFF) m_t1 = 64'h7FFFFFFF;
        if (m_t2 > 64'h7FFFFFFF) m_t2 = 64'h7FFFFFFF;
        sum = m_w + (s2 ? fx_mul(m_ap, m_t1) : 0) - (s1 ? fx_mul(m_am, m_t2) : 0);
        m_w = (sum < m_min) ? m_min : (sum > m_max) ? m_max : sum;
        check_state("step");
        tick();
        check("done_pulse", {31'd0, done}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("hold_w", weight, 32'(m_w));
    endtask

    initial begin
        reset = 1'b1; apply = 1'b0; init = 1'b0; step_ack = 1'b0; step_spike = 1'b0;
        i_ext = '0; weight_init = '0; weight_min = '0; weight_max = '0;
        a_plus = '0; a_minus = '0; decay = '0;
        m_w = 0; m_t1 = 0; m_t2 = 0; m_s1 = 0; m_s2 = 0;
        m_min = 0; m_max = 0; m_ap = 0; m_am = 0; m_dec = 0;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("rst_req", {31'd0, step_req}, 32'd0);
        check("rst_sel", {31'd0, step_sel}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_cur", step_current, 32'd0);
        check_state("rst");

        // Pre-then-post LTP
        do_init(32'h10000, 0, 32'h7FFFFFFF, 32'h4000, 0, 32'h8000);
        run_step(1, 0, 0, 0);
        run_step(0, 1, 0, 0);
        check("ltp_t1", trace1, 32'h8000);
        check("ltp_w", weight, 32'h12000);

        // Post-then-pre LTD
        do_init(32'h10000, 0, 32'h7FFFFFFF, 0, 32'h4000, 32'h8000);
        run_step(0, 1, 0, 0);
        run_step(1, 0, 0, 0);
        check("ltd_w", weight, 32'hE000);

        // Clamps
        do_init(32'h10000, 0, 32'h11000, 32'h4000, 0, 32'h8000);
        run_step(1, 0, 0, 0);
        run_step(0, 1, 0, 0);
        check("clamp_max", weight, 32'h11000);
        do_init(32'h10000, 32'hF000, 32'h7FFFFFFF, 0, 32'h4000, 32'h8000);
        run_step(0, 1, 0, 0);
        run_step(1, 0, 0, 0);
        check("clamp_min", weight, 32'hF000);

        // Coincident spikes
        do_init(32'h10000, 0, 32'h7FFFFFFF, 32'h4000, 32'h4000, 32'h8000);
        run_step(1, 1, 0, 0);
        check("coin_t1", trace1, 32'h10000);
        check("coin_t2", trace2, 32'h10000);
        check("coin_w", weight, 32'h10000);

        // Handshake stall with ignored apply pulses
        run_step(1, 1, 3, 1);
        run_step(0, 1, 2, 1);

        // init wins over apply
        init = 1'b1; apply = 1'b1;
        tick();
        init = 1'b0; apply = 1'b0;
        m_t1 = 0; m_t2 = 0; m_s1 = 0; m_s2 = 0; m_w = 32'(weight_init);
        check("init_wins_busy", {31'd0, busy}, 32'd0);
        check_state("init_wins");

        // Reset mid-STEP2
        apply = 1'b1;
        tick();
        apply = 1'b0;
        step_ack = 1'b1; step_spike = 1'b1;
        tick();
        step_ack = 1'b0; step_spike = 1'b0;
        check("pre_rst_sel", {31'd0, step_sel}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_req", {31'd0, step_req}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_w", weight, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        m_w = 0; m_t1 = 0; m_t2 = 0; m_s1 = 0; m_s2 = 0;
        step_ack = 1'b1; step_spike = 1'b1;
        tick(); tick(); tick();
        step_ack = 1'b0; step_spike = 1'b0;
        check("late_ack_req", {31'd0, step_req}, 32'd0);
        check("late_ack_busy", {31'd0, busy}, 32'd0);
        check("late_ack_done", {31'd0, done}, 32'd0);
        check_state("late_ack");

        // Randomized timesteps
        do_init(32'h10000, 32'h8000, 32'h30000, $urandom_range(0, 32'h8000),
                $urandom_range(0, 32'h8000), $urandom_range(0, 32'hFFFF));
        for (int k = 0; k < 24; k++) begin
            if (k == 12) begin
                decay = 32'($urandom_range(0, 32'hFFFF));
                m_dec = decay;
            end
            run_step(1'($urandom), 1'($urandom), $urandom_range(0, 2), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
